sti_rx: RTL and testbench

Serial-to-parallel receiver: the far end of the STI serial link.
- Consumes the bit stream from the STI transmitter (so_data/so_valid) and rebuilds the original 16-bit parallel word.
- Uses the same per-frame configuration as the transmitter: length, fill, msb-first, low-byte.
- Checks frame length and padding bits, counts frames, and raises a sticky finish flag after the final frame.
- Loopback checker / downstream consumer in the STI_DAC subsystem.

---
 rtl/sti_pkg.sv | 22 ++
 rtl/sti_rx_extract.sv | 52 +++++
 rtl/sti_rx.sv | 149 ++++++++++++++
 tb/tb_sti_rx.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sti_pkg.sv
// Shared definitions for the STI serial link: length encodings, state enum
// and the helper that maps a length code to a bit count.
package sti_pkg;

  localparam logic [1:0] LEN_8  = 2'b00;
  localparam logic [1:0] LEN_16 = 2'b01;
  localparam logic [1:0] LEN_24 = 2'b10;
  localparam logic [1:0] LEN_32 = 2'b11;

  typedef enum logic {IDLE, RECV} state_t;

  // Frame length in bits for a length code; 6 bits so 32 fits.
  function automatic logic [5:0] len_bits(input logic [1:0] len);
    case (len)
      LEN_8:   return 6'd8;
      LEN_16:  return 6'd16;
      LEN_24:  return 6'd24;
      default: return 6'd32;
    endcase
  endfunction

endpackage

// File: rtl/sti_rx_extract.sv
// Pulls the 16-bit payload and the pad bits out of an assembled frame word.
// Purely combinational so the transmitter-side model can reuse it.
module sti_rx_extract
  import sti_pkg::*;
#(
  parameter int DW  = 16,
  parameter int SRW = 32
) (
  input  logic [SRW-1:0] i_word,
  input  logic [1:0]     i_length,
  input  logic           i_fill,
  input  logic           i_low,
  output logic [DW-1:0]  o_data,
  output logic           o_pad_err
);

  logic [15:0] w_pad;

  // Select payload and pad field according to frame length and fill side.
  always_comb begin
    o_data = '0;
    w_pad  = '0;
    case (i_length)
      LEN_8: begin
        o_data = i_low ? {i_word[7:0], 8'h00} : {8'h00, i_word[7:0]};
      end
      LEN_16: begin
        o_data = i_word[15:0];
      end
      LEN_24: begin
        if (i_fill) begin
          o_data = i_word[23:8];
          w_pad  = {8'h00, i_word[7:0]};
        end else begin
          o_data = i_word[15:0];
          w_pad  = {8'h00, i_word[23:16]};
        end
      end
      default: begin
        if (i_fill) begin
          o_data = i_word[31:16];
          w_pad  = i_word[15:0];
        end else begin
          o_data = i_word[15:0];
          w_pad  = i_word[31:16];
        end
      end
    endcase
    o_pad_err = |w_pad;
  end

endmodule

// File: rtl/sti_rx.sv
// STI serial receiver: rebuilds the parallel word from the bit stream,
// flags length/pad errors, counts frames and latches the finish flag.
module sti_rx
  import sti_pkg::*;
#(
  parameter int DW   = 16,
  parameter int SRW  = 32,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cfg_load,
  input  logic [1:0]      cfg_length,
  input  logic            cfg_fill,
  input  logic            cfg_msb,
  input  logic            cfg_low,
  input  logic            cfg_end,
  input  logic            si_data,
  input  logic            si_valid,
  output logic [DW-1:0]   po_data,
  output logic            po_valid,
  output logic            len_err,
  output logic            pad_err,
  output logic [CNTW-1:0] frame_cnt,
  output logic            rx_finish
);

  state_t          r_state, w_state_next;
  logic [1:0]      r_cfg_length;
  logic            r_cfg_fill, r_cfg_msb, r_cfg_low, r_cfg_end;
  logic [SRW-1:0]  r_sr;
  logic [5:0]      r_bit_cnt;
  logic [DW-1:0]   r_po_data;
  logic            r_po_valid, r_len_err, r_pad_err, r_rx_finish;
  logic [CNTW-1:0] r_frame_cnt;

  logic            w_load_now, w_start, w_sample, w_done;
  logic [SRW-1:0]  w_sr_shift, w_sr_place;
  logic [DW-1:0]   w_ext_data;
  logic            w_ext_pad;
  logic [5:0]      w_len_n;

  // Config can only change between frames.
  assign w_load_now = cfg_load && (r_state == IDLE);
  assign w_len_n    = len_bits(r_cfg_length);

  // Next-bit candidates: MSB-first shifts left, LSB-first writes bit[count].
  for (genvar gi = 0; gi < SRW; gi++) begin : g_sr
    if (gi == 0) begin : g_lsb
      assign w_sr_shift[gi] = si_data;
    end else begin : g_up
      assign w_sr_shift[gi] = r_sr[gi-1];
    end
    assign w_sr_place[gi] = (r_bit_cnt == 6'(gi)) ? si_data : r_sr[gi];
  end

  sti_rx_extract #(.DW(DW), .SRW(SRW)) u_extract (
    .i_word    (r_sr),
    .i_length  (r_cfg_length),
    .i_fill    (r_cfg_fill),
    .i_low     (r_cfg_low),
    .o_data    (w_ext_data),
    .o_pad_err (w_ext_pad)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next state plus the start/sample/done strobes for the datapath.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_sample     = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (si_valid) begin
          w_start      = 1'b1;
          w_state_next = RECV;
        end
      end
      default: begin
        if (si_valid) begin
          w_sample = (r_bit_cnt < 6'd32);
        end else begin
          w_done       = 1'b1;
          w_state_next = IDLE;
        end
      end
    endcase
  end

  // Config latch, shift register, bit counter and result registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cfg_length <= '0;
      r_cfg_fill   <= 1'b0;
      r_cfg_msb    <= 1'b0;
      r_cfg_low    <= 1'b0;
      r_cfg_end    <= 1'b0;
      r_sr         <= '0;
      r_bit_cnt    <= '0;
      r_po_data    <= '0;
      r_po_valid   <= 1'b0;
      r_len_err    <= 1'b0;
      r_pad_err    <= 1'b0;
      r_frame_cnt  <= '0;
      r_rx_finish  <= 1'b0;
    end else begin
      r_po_valid <= 1'b0;
      if (w_load_now) begin
        r_cfg_length <= cfg_length;
        r_cfg_fill   <= cfg_fill;
        r_cfg_msb    <= cfg_msb;
        r_cfg_low    <= cfg_low;
        r_cfg_end    <= cfg_end;
      end
      if (w_start) begin
        // First bit sits in bit 0 for either bit order; clears stale data.
        r_sr      <= SRW'(si_data);
        r_bit_cnt <= 6'd1;
      end
      if ((r_state == RECV) && si_valid) begin
        if (w_sample) r_sr <= r_cfg_msb ? w_sr_shift : w_sr_place;
        if (r_bit_cnt != 6'd33) r_bit_cnt <= r_bit_cnt + 6'd1;
      end
      if (w_done) begin
        r_po_valid  <= 1'b1;
        r_po_data   <= w_ext_data;
        r_len_err   <= (r_bit_cnt != w_len_n);
        // A short frame reports only the length error.
        r_pad_err   <= (r_bit_cnt >= w_len_n) && w_ext_pad;
        r_frame_cnt <= r_frame_cnt + CNTW'(1);
        if (r_cfg_end) r_rx_finish <= 1'b1;
      end
    end
  end

  assign po_data   = r_po_data;
  assign po_valid  = r_po_valid;
  assign len_err   = r_len_err;
  assign pad_err   = r_pad_err;
  assign frame_cnt = r_frame_cnt;
  assign rx_finish = r_rx_finish;

endmodule

// File: tb/tb_sti_rx.sv
// Directed bench for sti_rx: serialises hand-chosen words and compares the
// rebuilt word, error flags, frame count and finish flag with expected values.
module tb_sti_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_load = 1'b0;
  logic [1:0]  cfg_length = 2'b00;
  logic        cfg_fill = 1'b0, cfg_msb = 1'b0, cfg_low = 1'b0, cfg_end = 1'b0;
  logic        si_data = 1'b0, si_valid = 1'b0;
  logic [15:0] po_data;
  logic        po_valid, len_err, pad_err, rx_finish;
  logic [7:0]  frame_cnt;

  int          tests = 0;
  int          failed = 0;
  logic [7:0]  exp_cnt = 8'd0;
  logic        g_valid, g_valid2, g_len, g_pad, g_fin;
  logic [15:0] g_data;
  logic [7:0]  g_cnt;

  sti_rx dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_length(cfg_length),
    .cfg_fill(cfg_fill), .cfg_msb(cfg_msb), .cfg_low(cfg_low), .cfg_end(cfg_end),
    .si_data(si_data), .si_valid(si_valid), .po_data(po_data), .po_valid(po_valid),
    .len_err(len_err), .pad_err(pad_err), .frame_cnt(frame_cnt), .rx_finish(rx_finish)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [1:0] len, input logic fill, input logic msb,
                         input logic low, input logic fin);
    cfg_length = len; cfg_fill = fill; cfg_msb = msb; cfg_low = low; cfg_end = fin;
  endtask

  task automatic load(input logic [1:0] len, input logic fill, input logic msb,
                      input logic low, input logic fin);
    set_cfg(len, fill, msb, low, fin);
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  // Send n bits of w (MSB-first or LSB-first), then one idle cycle; capture
  // outputs in the po_valid cycle and again one cycle later.
  task automatic run_frame(input logic [63:0] w, input int n, input logic msb_first,
                           input logic load_first);
    for (int i = 0; i < n; i++) begin
      si_valid = 1'b1;
      si_data  = msb_first ? w[n-1-i] : w[i];
      cfg_load = load_first && (i == 0);
      tick();
    end
    cfg_load = 1'b0; si_valid = 1'b0; si_data = 1'b0;
    tick();
    g_valid = po_valid; g_data = po_data; g_len = len_err; g_pad = pad_err;
    g_cnt = frame_cnt; g_fin = rx_finish;
    exp_cnt = exp_cnt + 8'd1;
    tick();
    g_valid2 = po_valid;
  endtask

  task automatic check_frame(input string tag, input logic [15:0] d, input logic le,
                             input logic pe);
    check({tag, " po_valid"}, 32'(g_valid), 32'd1);
    check({tag, " po_data"}, 32'(g_data), 32'(d));
    check({tag, " len_err"}, 32'(g_len), 32'(le));
    check({tag, " pad_err"}, 32'(g_pad), 32'(pe));
    check({tag, " frame_cnt"}, 32'(g_cnt), 32'(exp_cnt));
    check({tag, " pulse_end"}, 32'(g_valid2), 32'd0);
    $display("[TB] %s: data=%h len_err=%0d pad_err=%0d cnt=%0d", tag, g_data, g_len, g_pad, g_cnt);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst po_data", 32'(po_data), 32'd0);
    check("rst po_valid", 32'(po_valid), 32'd0);
    check("rst len_err", 32'(len_err), 32'd0);
    check("rst pad_err", 32'(pad_err), 32'd0);
    check("rst frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst rx_finish", 32'(rx_finish), 32'd0);
    reset = 1'b1;
    tick();

    load(2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    run_frame(64'hA53C, 16, 1'b1, 1'b0);
    check_frame("16b msb A53C", 16'hA53C, 1'b0, 1'b0);

    load(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    run_frame(64'h81, 8, 1'b0, 1'b0);
    check_frame("8b low=1 81", 16'h8100, 1'b0, 1'b0);
    load(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(64'h81, 8, 1'b0, 1'b0);
    check_frame("8b low=0 81", 16'h0081, 1'b0, 1'b0);

    load(2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    run_frame(64'hBEEF0000, 32, 1'b1, 1'b0);
    check_frame("32b fill=1", 16'hBEEF, 1'b0, 1'b0);
    load(2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    run_frame(64'h0000BEEF, 32, 1'b1, 1'b0);
    check_frame("32b fill=0", 16'hBEEF, 1'b0, 1'b0);
    load(2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    run_frame(64'hBEEF0001, 32, 1'b1, 1'b0);
    check_frame("32b pad bit", 16'hBEEF, 1'b0, 1'b1);

    load(2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
    run_frame(64'hABCD00, 24, 1'b1, 1'b0);
    check_frame("24b fill=1 msb", 16'hABCD, 1'b0, 1'b0);

    load(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(64'h001234, 24, 1'b0, 1'b0);
    check_frame("24b fill=0 lsb", 16'h1234, 1'b0, 1'b0);
    run_frame(64'h001234, 20, 1'b0, 1'b0);
    check_frame("24b short 20", 16'h1234, 1'b1, 1'b0);
    run_frame(64'h001234, 35, 1'b0, 1'b0);
    check_frame("24b long 35", 16'h1234, 1'b1, 1'b0);
    run_frame(64'h001234, 24, 1'b0, 1'b0);
    check_frame("24b after long", 16'h1234, 1'b0, 1'b0);

    // New config presented together with the first bit applies to that frame.
    set_cfg(2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    run_frame(64'hC5, 8, 1'b1, 1'b1);
    check_frame("8b load+first", 16'h00C5, 1'b0, 1'b0);

    // Reset in the middle of a frame aborts it.
    load(2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      si_valid = 1'b1; si_data = i[0];
      tick();
    end
    reset = 1'b0; si_valid = 1'b0; si_data = 1'b0;
    tick();
    reset = 1'b1;
    exp_cnt = 8'd0;
    for (int i = 0; i < 3; i++) begin
      check("abort po_valid", 32'(po_valid), 32'd0);
      tick();
    end
    check("abort frame_cnt", 32'(frame_cnt), 32'd0);
    load(2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    run_frame(64'hA53C, 16, 1'b1, 1'b0);
    check_frame("post-abort A53C", 16'hA53C, 1'b0, 1'b0);

    // Frame counting and the sticky finish flag.
    reset = 1'b0; tick(); reset = 1'b1; tick();
    exp_cnt = 8'd0;
    load(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 34; i++) run_frame(64'(i), 8, 1'b0, 1'b0);
    check("34 frame_cnt", 32'(g_cnt), 32'd34);
    check("34 rx_finish", 32'(g_fin), 32'd0);
    load(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    run_frame(64'h5A, 8, 1'b0, 1'b0);
    check_frame("35th end frame", 16'h005A, 1'b0, 1'b0);
    check("35 rx_finish", 32'(g_fin), 32'd1);
    load(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(64'h3C, 8, 1'b0, 1'b0);
    check_frame("36th after end", 16'h003C, 1'b0, 1'b0);
    check("36 rx_finish", 32'(g_fin), 32'd1);
    for (int i = 0; i < 220; i++) run_frame(64'(i), 8, 1'b0, 1'b0);
    check("256 wrap frame_cnt", 32'(frame_cnt), 32'd0);
    check("256 model cnt", 32'(g_cnt), 32'(exp_cnt));
    check("256 rx_finish", 32'(rx_finish), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
